traffic_phase_ctrl: RTL and testbench
=====================================

// Module: traffic_phase_ctrl
// PURPOSE
//  N-direction intersection phase controller, successor to the fixed two-light A/B controller.
//  Sequences directions in round-robin order: GREEN -> YELLOW -> ALL_RED -> next GREEN.
//  Supports per-direction demand (skip/rest-in-green), an all-red clearance interval and a
//  flashing-yellow mode while disabled. Feeds lamp LEDs and the seconds-to-7-segment display path.
// PARAMETERS
//  NUM_DIR    3           number of directions, 1..8
//  TICK_DIV   50_000_000  clk cycles per 1 s tick, >=2
//  GREEN_SEC  20          green duration in seconds, 1..99
//  YELLOW_SEC 3           yellow duration in seconds, 1..99
//  ALLRED_SEC 1           all-red clearance in seconds, 1..99
//  DIR_W      3           width of direction index, >= clog2(NUM_DIR), min 1
// PORTS
//  clk          in   1        system clock
//  rst_n        in   1        asynchronous active-low reset
//  i_en         in   1        1 = run phases, 0 = flashing-yellow mode
//  i_req        in   NUM_DIR  per-direction demand pulse or level; sampled every cycle
//  o_red        out  NUM_DIR  red lamp per direction
//  o_yellow     out  NUM_DIR  yellow lamp per direction
//  o_green      out  NUM_DIR  green lamp per direction
//  o_active_dir out  DIR_W    direction currently owning green/yellow
//  o_sec        out  7        seconds remaining in the current state (0 in FLASH)
//  o_tick       out  1        1-cycle pulse on every 1 s tick (debug/display blink)
// BEHAVIOUR
//  - All outputs are registered. Reset gives: state FLASH, all lamps 0, o_active_dir 0,
//    o_sec 0, o_tick 0, demand latches 0, tick counter 0, flash bit 0.
//  - Tick: counter counts 0..TICK_DIV-1 and pulses o_tick on the wrap. It is held at 0 in FLASH
//    and restarts from 0 on the cycle i_en rises.
//  - States: FLASH, GREEN, YELLOW, ALL_RED.
//  - FLASH (i_en=0; entered on the next clk edge from any state):
//    - o_red=o_green=0; o_yellow = all bits equal to the flash bit.
//    - The flash bit toggles on every internal 1 s count; it uses a free count while in FLASH.
//    - o_sec=0; demand latches cleared.
//  - FLASH -> ALL_RED when i_en=1: o_sec=ALLRED_SEC, o_active_dir=NUM_DIR-1, so the first
//    green goes to dir 0 when no demand is present.
//  - Timing: on entering a state, o_sec loads its duration. Each tick decrements o_sec.
//    A tick with o_sec==1 leaves the state. The display therefore shows DUR..1 and each state
//    lasts exactly DUR ticks.
//  - GREEN -> YELLOW. YELLOW -> ALL_RED. ALL_RED -> GREEN of the selected direction.
//  - Lamps:
//    - GREEN: only o_green[dir] set.
//    - YELLOW: only o_yellow[dir] set.
//    - ALL_RED: o_red all ones.
//    - In GREEN/YELLOW, o_red = ~(1<<dir).
//  - Demand: req_q[d] is set by i_req[d]=1 and cleared on the cycle dir d enters GREEN.
//    A simultaneous set and clear leaves req_q[d]=1 only if i_req[d] is still 1.
//  - Next-direction select, at the ALL_RED exit: the first d with req_q[d]=1, searching
//    round-robin from o_active_dir+1. If no demand exists, use o_active_dir+1 mod NUM_DIR.
//  - Rest-in-green: at GREEN expiry, if no req_q bit other than the active dir is set, stay in
//    GREEN and reload o_sec=GREEN_SEC. Never enter YELLOW without a competing demand.
//    Exception: NUM_DIR==1 always rests in green.
//  - i_en falling mid-phase: abandon the phase immediately and go to FLASH; no yellow is forced.
//    i_en glitch (1 cycle low): full FLASH entry/exit, restarting in ALL_RED.
//  - rst_n asserted mid-operation: all state clears asynchronously to the reset values above.
//    Outputs return the cycle after rst_n deasserts, per i_en.
//  - Width rules: o_sec is 7 bit unsigned and never underflows; durations are checked at
//    elaboration (1..99).
// STRUCTURE
//  - traffic_pkg: state enum (FLASH, GREEN, YELLOW, ALL_RED, 2 bit), SEC_W=7, and the
//    rr_next() round-robin function.
//  - Sub-module sec_tick_gen (parameter TICK_DIV; ports clk, rst_n, i_clr, o_tick).
//  - Main FSM, demand latches and lamp decode stay in this module.
// TESTING (NUM_DIR=3, TICK_DIV=4, GREEN=3, YELLOW=2, ALLRED=1)
//  1. Reset with i_en=0 -> lamps 0, o_sec 0. o_yellow toggles 000/111 every 4 clk.
//  2. i_en=1 with i_req=3'b111 held -> ALL_RED 1 tick, then G0 (o_sec 3,2,1), Y0 (2,1),
//     ALL_RED, G1, Y1, ALL_RED, G2. Green state length = 12 clk.
//  3. Only i_req[2] pulsed during G0 -> after Y0/ALL_RED, G2 (dir 1 skipped); req_q[2] clears.
//  4. No demand after G0 -> o_green=001 persists; o_sec cycles 3,2,1,3... Pulse i_req[1] ->
//     Y0 follows at the next expiry.
//  5. i_en dropped during Y1 -> next cycle FLASH, o_red=000. Re-enable -> ALL_RED, o_sec=1,
//     tick counter restarts.
//  6. rst_n pulsed low mid-GREEN (asynchronous, between edges) -> outputs 0 immediately;
//     demand latches cleared.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared phase encoding, display width and the round-robin direction picker
// for the intersection phase controller.
package traffic_pkg;

  typedef logic [1:0] phase_t;

  localparam phase_t ST_FLASH   = 2'd0;
  localparam phase_t ST_GREEN   = 2'd1;
  localparam phase_t ST_YELLOW  = 2'd2;
  localparam phase_t ST_ALL_RED = 2'd3;

  localparam int SEC_W = 7;

  // First set bit of req searching upward from cur+1 with wrap; cur+1 if none set.
  function automatic logic [2:0] rr_next(input logic [7:0] req, input logic [2:0] cur,
                                         input int ndir);
    int base;
    int d;
    logic [2:0] pick;
    base = (int'(cur) + 1) % ndir;
    pick = 3'(base);
    for (int k = 7; k >= 0; k--) begin
      d = base + k;
      if (d >= ndir) d = d - ndir;
      if (k < ndir && req[d[2:0]]) pick = 3'(d);
    end
    return pick;
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_sec_tick_gen.sv
// One-second strobe: counts 0..TICK_DIV-1 and flags the last count.
// Held at zero while i_clr is high, so counting restarts cleanly on release.
module sec_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign o_tick = ~i_clr & (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (i_clr || o_tick) cnt <= '0;
    else                     cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-direction round-robin phase controller with demand skip, rest-in-green,
// all-red clearance and flashing yellow while disabled. Outputs are registered.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_DIR    = 3,
  parameter int TICK_DIV   = 50_000_000,
  parameter int GREEN_SEC  = 20,
  parameter int YELLOW_SEC = 3,
  parameter int ALLRED_SEC = 1,
  parameter int DIR_W      = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_en,
  input  logic [NUM_DIR-1:0] i_req,
  output logic [NUM_DIR-1:0] o_red,
  output logic [NUM_DIR-1:0] o_yellow,
  output logic [NUM_DIR-1:0] o_green,
  output logic [DIR_W-1:0]   o_active_dir,
  output logic [SEC_W-1:0]   o_sec,
  output logic               o_tick
);

  if (NUM_DIR < 1 || NUM_DIR > 8 || TICK_DIV < 2 || DIR_W < 1 || (1 << DIR_W) < NUM_DIR ||
      GREEN_SEC < 1 || GREEN_SEC > 99 || YELLOW_SEC < 1 || YELLOW_SEC > 99 ||
      ALLRED_SEC < 1 || ALLRED_SEC > 99) begin : g_param_err
    $error("traffic_phase_ctrl: parameter out of range");
  end

  localparam logic [SEC_W-1:0] G_LD = SEC_W'(GREEN_SEC);
  localparam logic [SEC_W-1:0] Y_LD = SEC_W'(YELLOW_SEC);
  localparam logic [SEC_W-1:0] R_LD = SEC_W'(ALLRED_SEC);

  phase_t             state, state_n;
  logic [DIR_W-1:0]   dir_n;
  logic [SEC_W-1:0]   sec_n;
  logic [NUM_DIR-1:0] req_q, req_n, grant, others, onehot;
  logic [NUM_DIR-1:0] red_n, yellow_n, green_n;
  logic               flash, flash_n;
  logic               tick, ftick, run_clr, flash_clr;

  // Phase timing only runs while enabled; the blink count only runs while flashing.
  assign run_clr   = ~i_en | (state == ST_FLASH);
  assign flash_clr =  i_en | (state != ST_FLASH);

  sec_tick_gen #(.TICK_DIV(TICK_DIV)) u_run_tick (
    .clk(clk), .rst_n(rst_n), .i_clr(run_clr), .o_tick(tick)
  );

  sec_tick_gen #(.TICK_DIV(TICK_DIV)) u_flash_tick (
    .clk(clk), .rst_n(rst_n), .i_clr(flash_clr), .o_tick(ftick)
  );

  assign others = req_q & ~(NUM_DIR'(1) << o_active_dir);

  always_comb begin
    state_n = state;
    dir_n   = o_active_dir;
    sec_n   = o_sec;
    flash_n = 1'b0;
    grant   = '0;
    if (!i_en) begin
      state_n = ST_FLASH;
      sec_n   = '0;
      if (state == ST_FLASH) flash_n = flash ^ ftick;
    end else if (state == ST_FLASH) begin
      state_n = ST_ALL_RED;
      sec_n   = R_LD;
      dir_n   = DIR_W'(NUM_DIR - 1);
    end else if (tick) begin
      if (o_sec > 7'd1) begin
        sec_n = o_sec - 7'd1;
      end else begin
        case (state)
          ST_GREEN: begin
            // Hold green until some other direction is actually waiting.
            if (NUM_DIR == 1 || others == '0) begin
              sec_n = G_LD;
            end else begin
              state_n = ST_YELLOW;
              sec_n   = Y_LD;
            end
          end
          ST_YELLOW: begin
            state_n = ST_ALL_RED;
            sec_n   = R_LD;
          end
          default: begin
            state_n = ST_GREEN;
            sec_n   = G_LD;
            dir_n   = DIR_W'(rr_next(8'(req_q), 3'(o_active_dir), NUM_DIR));
            grant   = NUM_DIR'(1) << dir_n;
          end
        endcase
      end
    end
    req_n = i_en ? ((req_q & ~grant) | i_req) : '0;
  end

  always_comb begin
    onehot   = NUM_DIR'(1) << dir_n;
    red_n    = '0;
    yellow_n = '0;
    green_n  = '0;
    case (state_n)
      ST_FLASH:  yellow_n = {NUM_DIR{flash_n}};
      ST_GREEN:  begin green_n  = onehot; red_n = ~onehot; end
      ST_YELLOW: begin yellow_n = onehot; red_n = ~onehot; end
      default:   red_n = '1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_FLASH;
      o_active_dir <= '0;
      o_sec        <= '0;
      req_q        <= '0;
      flash        <= 1'b0;
      o_red        <= '0;
      o_yellow     <= '0;
      o_green      <= '0;
      o_tick       <= 1'b0;
    end else begin
      state        <= state_n;
      o_active_dir <= dir_n;
      o_sec        <= sec_n;
      req_q        <= req_n;
      flash        <= flash_n;
      o_red        <= red_n;
      o_yellow     <= yellow_n;
      o_green      <= green_n;
      o_tick       <= tick;
    end
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl: per-cycle comparison against a phase/seconds
// model plus hand-computed checks of sequencing, skip, rest, disable and reset.
module tb_traffic_phase_ctrl;

  localparam int ND = 3;
  localparam int TD = 4;
  localparam int GS = 3;
  localparam int YS = 2;
  localparam int AS = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [ND-1:0] req = '0;
  logic [ND-1:0] o_red, o_yellow, o_green;
  logic [2:0]    o_active_dir;
  logic [6:0]    o_sec;
  logic          o_tick;

  int tests = 0;
  int fails = 0;
  logic [ND-1:0] green_seen;

  traffic_phase_ctrl #(
    .NUM_DIR(ND), .TICK_DIV(TD), .GREEN_SEC(GS), .YELLOW_SEC(YS), .ALLRED_SEC(AS), .DIR_W(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_en(en), .i_req(req),
    .o_red(o_red), .o_yellow(o_yellow), .o_green(o_green),
    .o_active_dir(o_active_dir), .o_sec(o_sec), .o_tick(o_tick)
  );

  always #5 clk = ~clk;

  // Model: phase 0=flash 1=green 2=yellow 3=all-red, seconds left, cycle within second.
  int            m_ph = 0, m_dir = 0, m_sec = 0, m_cyc = 0, m_fcyc = 0;
  bit [ND-1:0]   m_dem = '0;
  bit            m_flash = 0, m_tick = 0;

  always @(posedge clk or negedge rst_n) begin
    bit tk, ftk, busy, found;
    int nxt, d;
    bit [ND-1:0] grant;
    if (!rst_n) begin
      m_ph = 0; m_dir = 0; m_sec = 0; m_cyc = 0; m_fcyc = 0;
      m_dem = '0; m_flash = 0; m_tick = 0;
    end else begin
      tk  = (m_ph != 0) && en && (m_cyc == TD - 1);
      ftk = (m_ph == 0) && !en && (m_fcyc == TD - 1);
      m_tick = tk;
      grant = '0;
      if (!en) begin
        m_flash = (m_ph == 0) ? (m_flash ^ ftk) : 1'b0;
        m_fcyc  = (m_ph == 0) ? (m_fcyc + 1) % TD : 0;
        m_cyc = 0; m_ph = 0; m_sec = 0; m_dem = '0;
      end else begin
        m_flash = 0; m_fcyc = 0;
        if (m_ph == 0) begin
          m_ph = 3; m_sec = AS; m_dir = ND - 1; m_cyc = 0;
        end else begin
          m_cyc = (m_cyc + 1) % TD;
          if (tk) begin
            if (m_sec > 1) m_sec = m_sec - 1;
            else if (m_ph == 1) begin
              busy = 0;
              for (int k = 0; k < ND; k++) if (k != m_dir && m_dem[k]) busy = 1;
              if (busy) begin m_ph = 2; m_sec = YS; end
              else m_sec = GS;
            end else if (m_ph == 2) begin
              m_ph = 3; m_sec = AS;
            end else begin
              nxt = (m_dir + 1) % ND;
              found = 0;
              for (int k = 0; k < ND; k++) begin
                d = (m_dir + 1 + k) % ND;
                if (!found && m_dem[d]) begin nxt = d; found = 1; end
              end
              m_dir = nxt; m_ph = 1; m_sec = GS; grant[nxt] = 1'b1;
            end
          end
        end
        m_dem = (m_dem & ~grant) | req;
      end
    end
  end

  function automatic logic [3*ND-1:0] exp_lamps();
    logic [ND-1:0] r, y, g, one;
    r = '0; y = '0; g = '0;
    one = ND'(1) << m_dir;
    if (m_ph == 0) y = {ND{m_flash}};
    else if (m_ph == 1) begin g = one; r = ~one; end
    else if (m_ph == 2) begin y = one; r = ~one; end
    else r = '1;
    return {r, y, g};
  endfunction

  always @(negedge clk) begin
    logic [3*ND-1:0] e;
    e = exp_lamps();
    tests++;
    if ({o_red, o_yellow, o_green} !== e || o_active_dir !== 3'(m_dir) ||
        o_sec !== 7'(m_sec) || o_tick !== m_tick) begin
      fails++;
      $display("FAIL model_cmp t=%0t dut r/y/g=%b/%b/%b dir=%0d sec=%0d tick=%b need r/y/g=%b/%b/%b dir=%0d sec=%0d tick=%b",
               $time, o_red, o_yellow, o_green, o_active_dir, o_sec, o_tick,
               e[3*ND-1:2*ND], e[2*ND-1:ND], e[ND-1:0], m_dir, m_sec, m_tick);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // sel: 0 green, 1 yellow, 2 red
  task automatic wait_lamp(input int sel, input logic [ND-1:0] val, input int budget,
                           input string name);
    logic [ND-1:0] cur;
    bit hit;
    hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      cur = (sel == 0) ? o_green : (sel == 1) ? o_yellow : o_red;
      green_seen |= o_green;
      if (cur == val) hit = 1;
      else cyc();
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL %s: timeout, lamp not %b after %0d cycles", name, val, budget);
    end
  endtask

  initial begin
    int n, prev_sec;
    bit wrapped;
    logic [ND-1:0] ysum;

    // 1. reset and flashing yellow
    repeat (2) @(posedge clk);
    #2;
    chk("rst_sec", int'(o_sec), 0);
    chk("rst_lamps", int'({o_red, o_yellow, o_green}), 0);
    chk("rst_dir", int'(o_active_dir), 0);
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      chk($sformatf("flash_y%0d", i), int'(o_yellow), (i >= 4 && i < 8) ? 7 : 0);
    end

    // 2. full demand round robin
    cyc();
    en = 1'b1; req = 3'b111;
    cyc();
    chk("en_allred", int'(o_red), 7);
    chk("en_sec", int'(o_sec), 1);
    chk("en_dir", int'(o_active_dir), 2);
    wait_lamp(0, 3'b001, 8, "g0_start");
    chk("g0_sec", int'(o_sec), 3);
    n = 1;
    for (int i = 0; i < 40 && o_green == 3'b001; i++) begin
      cyc();
      if (o_green == 3'b001) n++;
    end
    chk("g0_len", n, 12);
    wait_lamp(0, 3'b010, 30, "g1_start");
    chk("g1_dir", int'(o_active_dir), 1);
    wait_lamp(0, 3'b100, 30, "g2_start");

    // 3. single demand skips dir 1
    req = '0; en = 1'b0;
    cyc(); cyc();
    en = 1'b1;
    wait_lamp(0, 3'b001, 10, "g0_again");
    cyc();
    req = 3'b100;
    cyc();
    req = '0;
    green_seen = '0;
    wait_lamp(0, 3'b100, 40, "skip_to_g2");
    chk("skip_dir", int'(o_active_dir), 2);
    chk("skip_no_g1", int'(green_seen & 3'b010), 0);

    // 4. rest in green, then a competing request
    ysum = '0; wrapped = 0; prev_sec = int'(o_sec);
    for (int i = 0; i < 30; i++) begin
      cyc();
      ysum |= o_yellow;
      if (prev_sec == 1 && o_sec == 7'd3 && o_green == 3'b100) wrapped = 1;
      prev_sec = int'(o_sec);
    end
    chk("rest_no_yellow", int'(ysum), 0);
    chk("rest_reload", int'(wrapped), 1);
    chk("rest_green", int'(o_green), 4);
    req = 3'b010;
    cyc();
    req = '0;
    wait_lamp(1, 3'b100, 20, "y2_after_req");
    wait_lamp(0, 3'b010, 20, "g1_after_req");

    // 5. disable mid-yellow, re-enable
    req = 3'b001;
    cyc();
    req = '0;
    wait_lamp(1, 3'b010, 20, "y1");
    en = 1'b0;
    cyc();
    chk("dis_red", int'(o_red), 0);
    chk("dis_lamps", int'({o_yellow, o_green}), 0);
    chk("dis_sec", int'(o_sec), 0);
    cyc(); cyc();
    en = 1'b1;
    cyc();
    chk("reen_red", int'(o_red), 7);
    chk("reen_sec", int'(o_sec), 1);
    n = 1;
    for (int i = 0; i < 10 && o_red == 3'b111; i++) begin
      cyc();
      if (o_red == 3'b111) n++;
    end
    chk("reen_allred_len", n, 4);
    chk("reen_g0", int'(o_green), 1);

    // enable glitch: one low cycle forces flash then all-red
    en = 1'b0;
    cyc();
    chk("glitch_flash", int'({o_red, o_green}), 0);
    en = 1'b1;
    cyc();
    chk("glitch_allred", int'(o_red), 7);
    chk("glitch_sec", int'(o_sec), 1);

    // 6. asynchronous reset mid-green clears demand
    wait_lamp(0, 3'b001, 10, "g0_pre_rst");
    req = 3'b010;
    cyc();
    req = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_lamps", int'({o_red, o_yellow, o_green}), 0);
    chk("arst_sec", int'(o_sec), 0);
    chk("arst_dir", int'(o_active_dir), 0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_allred", int'(o_red), 7);
    green_seen = '0;
    wait_lamp(0, 3'b001, 10, "post_rst_g0");
    chk("post_rst_no_demand", int'(green_seen), 1);

    cyc(); cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
